// File: rtl/mini_cpu_pkg.sv
// Shared constants for the mini-CPU control slice: opcodes, FSM state encodings and default widths.
package mini_cpu_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;

    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_ADDI    = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_SUBI    = 3'b100;
    localparam logic [2:0] OP_MUL     = 3'b101;
    localparam logic [2:0] OP_CLEAR   = 3'b110;
    localparam logic [2:0] OP_DISPLAY = 3'b111;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_SHOW   = 3'd5
    } state_t;

    // Opcodes LOAD..MUL write their result back to the register file.
    function automatic logic writes_ram(input logic [2:0] op);
        return (op <= OP_MUL);
    endfunction

endpackage

// File: rtl/mini_cpu_button_edge.sv
// Active-low button front end: 2-FF synchroniser, optional filter (MINI_CPU_DEBOUNCE_EN), release pulse.
module mini_cpu_button_edge
`ifdef MINI_CPU_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 16
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rel
);

    logic sync1_r;
    logic sync2_r;
    logic level_s;
    logic prev_r;

    // Two-stage synchroniser; idles high so reset never looks like a release.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

`ifdef MINI_CPU_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          stable_r;
    logic [CW-1:0] cnt_r;

    // Accept a new level only after it has been seen on DEBOUNCE_CYCLES consecutive samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_r <= 1'b1;
            cnt_r    <= '0;
        end else if (sync2_r == stable_r) begin
            cnt_r    <= '0;
        end else if (cnt_r == CNT_LAST) begin
            stable_r <= sync2_r;
            cnt_r    <= '0;
        end else begin
            cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign level_s = stable_r;
`else
    assign level_s = sync2_r;
`endif

    // Previous accepted level for 0->1 (release) detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r <= 1'b1;
        end else begin
            prev_r <= level_s;
        end
    end

    assign rel = level_s & ~prev_r;

endmodule

// File: rtl/mini_cpu_control_unit.sv
// Mini-CPU control unit: button handling, instruction sequencing, RAM/ALU/LCD control.
// Build option MINI_CPU_DEBOUNCE_EN adds a level filter on both buttons.
module mini_cpu_control_unit
    import mini_cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
`ifdef MINI_CPU_DEBOUNCE_EN
    , parameter int DEBOUNCE_CYCLES = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ligar,
    input  logic              enviar,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [6:0]        addr3OuImm,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              lcd_busy,
    output logic [ADDR_W-1:0] ram_raddr1,
    output logic [ADDR_W-1:0] ram_raddr2,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_clr,
    output logic [2:0]        alu_op,
    output logic [6:0]        alu_imm,
    output logic              lcd_valid,
    output logic [2:0]        lcd_op,
    output logic [ADDR_W-1:0] lcd_addr,
    output logic [DATA_W-1:0] lcd_value,
    output logic              cpu_on
);

    state_t            state_r;
    state_t            state_nxt_s;
    logic              ligar_rel_s;
    logic              enviar_rel_s;
    logic [2:0]        op_r;
    logic [ADDR_W-1:0] a1_r;

`ifdef MINI_CPU_DEBOUNCE_EN
    mini_cpu_button_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ligar_edge (
        .clk(clk), .rst(rst), .btn(ligar), .rel(ligar_rel_s)
    );
    mini_cpu_button_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enviar_edge (
        .clk(clk), .rst(rst), .btn(enviar), .rel(enviar_rel_s)
    );
`else
    mini_cpu_button_edge u_ligar_edge (
        .clk(clk), .rst(rst), .btn(ligar), .rel(ligar_rel_s)
    );
    mini_cpu_button_edge u_enviar_edge (
        .clk(clk), .rst(rst), .btn(enviar), .rel(enviar_rel_s)
    );
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_OFF;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; power toggling overrides everything, including a same-cycle send.
    always_comb begin
        state_nxt_s = state_r;
        if (ligar_rel_s) begin
            if (state_r == ST_OFF) begin
                state_nxt_s = ST_FETCH;
            end else begin
                state_nxt_s = ST_OFF;
            end
        end else begin
            case (state_r)
                ST_OFF:    state_nxt_s = ST_OFF;
                ST_FETCH: begin
                    if (enviar_rel_s) begin
                        state_nxt_s = ST_DECODE;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end
                ST_DECODE: state_nxt_s = ST_EXEC;
                ST_EXEC:   state_nxt_s = ST_WRITE;
                ST_WRITE:  state_nxt_s = ST_SHOW;
                ST_SHOW: begin
                    if (lcd_busy) begin
                        state_nxt_s = ST_SHOW;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end
                default:   state_nxt_s = ST_OFF;
            endcase
        end
    end

    // Registered outputs, updated on the edge that enters the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_raddr1 <= '0;
            ram_raddr2 <= '0;
            ram_we     <= 1'b0;
            ram_waddr  <= '0;
            ram_wdata  <= '0;
            ram_clr    <= 1'b0;
            alu_op     <= 3'd0;
            alu_imm    <= 7'd0;
            lcd_valid  <= 1'b0;
            lcd_op     <= 3'd0;
            lcd_addr   <= '0;
            lcd_value  <= '0;
            cpu_on     <= 1'b0;
            op_r       <= 3'd0;
            a1_r       <= '0;
        end else begin
            ram_we  <= 1'b0;
            ram_clr <= 1'b0;
            if ((state_r != ST_OFF) && (state_nxt_s == ST_OFF)) begin
                cpu_on    <= 1'b0;
                lcd_valid <= 1'b0;
            end else begin
                case (state_r)
                    ST_OFF: begin
                        if (state_nxt_s == ST_FETCH) begin
                            cpu_on  <= 1'b1;
                            ram_clr <= 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        if (state_nxt_s == ST_DECODE) begin
                            op_r       <= opcode;
                            a1_r       <= addr1;
                            ram_waddr  <= addr1;
                            ram_raddr1 <= (opcode == OP_DISPLAY) ? addr1 : addr2;
                            ram_raddr2 <= ADDR_W'(addr3OuImm[6:3]);
                            alu_op     <= opcode;
                            alu_imm    <= addr3OuImm;
                        end
                    end
                    ST_EXEC: begin
                        ram_wdata <= alu_result;
                        if (writes_ram(op_r)) begin
                            ram_we <= 1'b1;
                        end else if (op_r == OP_CLEAR) begin
                            ram_clr <= 1'b1;
                        end
                    end
                    ST_WRITE: begin
                        // For DISPLAY the ALU passes RAM port-1 data, so ram_wdata already holds it.
                        lcd_valid <= 1'b1;
                        lcd_op    <= op_r;
                        lcd_addr  <= a1_r;
                        lcd_value <= (op_r == OP_CLEAR) ? '0 : ram_wdata;
                    end
                    ST_SHOW: begin
                        if (!lcd_busy) begin
                            lcd_valid <= 1'b0;
                        end
                    end
                    default: begin
                        lcd_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
